// File: rtl/jpeg_enc_pkg.sv
// Shared sizing constants and small types for the JPEG encoder data-unit buffering.
package jpeg_enc_pkg;

   localparam int JE_DU_DEPTH = 64;
   localparam int JE_NUM_CH   = 3;
   localparam int JE_SAMPLE_W = 8;

   typedef logic je_bank_t;

endpackage

// File: rtl/jpeg_enc_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register holds its value when no read is issued.
module jpeg_enc_sdp_ram #(
   parameter int DW = 8,
   parameter int AW = 9
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Only the output register is reset; array contents are left alone.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/jpeg_enc_du_pingpong_ram.sv
// Ping-pong data-unit RAM: one bank is filled by the pixel writer while the other is drained by the FDCT.
// Tracks bank ownership with a 0..2 full count and flags any protocol misuse in a sticky err.
module jpeg_enc_du_pingpong_ram
   import jpeg_enc_pkg::*;
#(
   parameter int   DATA_W   = JE_SAMPLE_W,
   parameter int   DU_DEPTH = JE_DU_DEPTH,
   parameter int   NUM_CH   = JE_NUM_CH,
   localparam int  IW       = $clog2(DU_DEPTH),
   localparam int  CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              flush_i,
   input  logic [CW-1:0]     wr_ch_i,
   input  logic [IW-1:0]     wr_idx_i,
   input  logic [DATA_W-1:0] wr_d_i,
   input  logic              wr_we_i,
   input  logic              wr_done_i,
   output logic              wr_ready_o,
   input  logic [CW-1:0]     rd_ch_i,
   input  logic [IW-1:0]     rd_idx_i,
   input  logic              rd_en_i,
   output logic [DATA_W-1:0] rd_d_o,
   output logic              rd_valid_o,
   input  logic              rd_done_i,
   output logic              rd_ready_o,
   output logic              err_o
);

   localparam int            AW  = 1 + CW + IW;
   localparam logic [CW:0]   NCH = (CW+1)'(NUM_CH);

   logic [1:0] full_cnt_q, full_cnt_d;
   je_bank_t   wr_bank_q, wr_bank_d;
   je_bank_t   rd_bank_q, rd_bank_d;
   logic       rd_valid_q, rd_valid_d;
   logic       err_q, err_d;

   logic wr_ready, rd_ready, wr_ch_ok, rd_ch_ok;
   logic wr_fire, rd_fire, wr_adv, rd_adv, proto_err;

   assign wr_ready = (full_cnt_q != 2'd2);
   assign rd_ready = (full_cnt_q != 2'd0);
   assign wr_ch_ok = ({1'b0, wr_ch_i} < NCH);
   assign rd_ch_ok = ({1'b0, rd_ch_i} < NCH);

   assign wr_fire = wr_we_i & wr_ready & wr_ch_ok;
   assign rd_fire = rd_en_i & rd_ready & rd_ch_ok & ~flush_i;
   assign wr_adv  = wr_done_i & wr_ready;
   assign rd_adv  = rd_done_i & rd_ready;

   assign proto_err = (wr_we_i & ~(wr_ready & wr_ch_ok))
                    | (wr_done_i & ~wr_ready)
                    | (rd_en_i & ~(rd_ready & rd_ch_ok))
                    | (rd_done_i & ~rd_ready);

   // Flush outranks both done pulses; simultaneous legal dones swap banks without changing occupancy.
   always_comb begin
      full_cnt_d = full_cnt_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      rd_valid_d = rd_fire;
      err_d      = err_q | proto_err;
      if (flush_i) begin
         full_cnt_d = 2'd0;
         wr_bank_d  = 1'b0;
         rd_bank_d  = 1'b0;
         rd_valid_d = 1'b0;
         err_d      = 1'b0;
      end else begin
         if (wr_adv) begin
            wr_bank_d = ~wr_bank_q;
         end
         if (rd_adv) begin
            rd_bank_d = ~rd_bank_q;
         end
         if (wr_adv && !rd_adv) begin
            full_cnt_d = full_cnt_q + 2'd1;
         end else if (rd_adv && !wr_adv) begin
            full_cnt_d = full_cnt_q - 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         full_cnt_q <= 2'd0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         full_cnt_q <= full_cnt_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         rd_valid_q <= rd_valid_d;
         err_q      <= err_d;
      end
   end

   jpeg_enc_sdp_ram #(
      .DW (DATA_W),
      .AW (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .rst_ni  (reset_n_i),
      .we_i    (wr_fire),
      .waddr_i ({wr_bank_q, wr_ch_i, wr_idx_i}),
      .wdata_i (wr_d_i),
      .re_i    (rd_fire),
      .raddr_i ({rd_bank_q, rd_ch_i, rd_idx_i}),
      .rdata_o (rd_d_o)
   );

   assign wr_ready_o = wr_ready;
   assign rd_ready_o = rd_ready;
   assign rd_valid_o = rd_valid_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_jpeg_enc_du_pingpong_ram.sv
// Bench for the ping-pong DU RAM: directed protocol scenarios plus a randomized phase,
// all compared against a bank/occupancy reference model kept here.
module tb_jpeg_enc_du_pingpong_ram;

   logic        clk = 1'b0;
   logic        rstN;
   logic        flush, wrWe, wrDone, rdEn, rdDone;
   logic [1:0]  wrCh, rdCh;
   logic [5:0]  wrIdx, rdIdx;
   logic [7:0]  wrD;
   logic        wrReady, rdReady, rdValid, err;
   logic [7:0]  rdD;

   logic        flush2, w2We, w2Done, r2En, r2Done;
   logic [1:0]  w2Ch, r2Ch;
   logic [5:0]  w2Idx, r2Idx;
   logic [11:0] w2D;
   logic        w2Ready, r2Ready, r2Valid, err2;
   logic [11:0] r2D;

   int tests = 0;
   int failures = 0;

   int          fullM;
   bit          wrBankM, rdBankM, errM, rdValidM;
   logic [7:0]  rdDM;
   logic [7:0]  memM [2][4][64];

   always #5 clk = ~clk;

   jpeg_enc_du_pingpong_ram dut (
      .clk_i(clk), .reset_n_i(rstN), .flush_i(flush),
      .wr_ch_i(wrCh), .wr_idx_i(wrIdx), .wr_d_i(wrD), .wr_we_i(wrWe),
      .wr_done_i(wrDone), .wr_ready_o(wrReady),
      .rd_ch_i(rdCh), .rd_idx_i(rdIdx), .rd_en_i(rdEn), .rd_d_o(rdD),
      .rd_valid_o(rdValid), .rd_done_i(rdDone), .rd_ready_o(rdReady), .err_o(err)
   );

   jpeg_enc_du_pingpong_ram #(.DATA_W(12), .NUM_CH(4)) dut2 (
      .clk_i(clk), .reset_n_i(rstN), .flush_i(flush2),
      .wr_ch_i(w2Ch), .wr_idx_i(w2Idx), .wr_d_i(w2D), .wr_we_i(w2We),
      .wr_done_i(w2Done), .wr_ready_o(w2Ready),
      .rd_ch_i(r2Ch), .rd_idx_i(r2Idx), .rd_en_i(r2En), .rd_d_o(r2D),
      .rd_valid_o(r2Valid), .rd_done_i(r2Done), .rd_ready_o(r2Ready), .err_o(err2)
   );

   // One comparison: counts it and reports tag/observed/expected on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clearInputs();
      flush = 0; wrWe = 0; wrDone = 0; rdEn = 0; rdDone = 0;
      flush2 = 0; w2We = 0; w2Done = 0; r2En = 0; r2Done = 0;
   endtask

   task automatic resetModel();
      fullM = 0; wrBankM = 0; rdBankM = 0; errM = 0; rdValidM = 0; rdDM = '0;
   endtask

   // Applies the current inputs for one clock, advances the model, then checks every output.
   task automatic applyStimulus();
      bit         wrRdy, rdRdy, wrOk, rdOk, wAcc, rAcc;
      logic [7:0] rdNext;
      wrRdy  = (fullM != 2);
      rdRdy  = (fullM != 0);
      wrOk   = wrWe && wrRdy && (wrCh < 3);
      rdOk   = rdEn && rdRdy && (rdCh < 3) && !flush;
      rdNext = memM[rdBankM][rdCh][rdIdx];
      if (wrOk) memM[wrBankM][wrCh][wrIdx] = wrD;
      if (flush) begin
         fullM = 0; wrBankM = 0; rdBankM = 0; errM = 0; rdValidM = 0;
      end else begin
         if (wrWe && !(wrRdy && wrCh < 3)) errM = 1;
         if (wrDone && !wrRdy) errM = 1;
         if (rdEn && !(rdRdy && rdCh < 3)) errM = 1;
         if (rdDone && !rdRdy) errM = 1;
         wAcc = wrDone && wrRdy;
         rAcc = rdDone && rdRdy;
         if (wAcc) begin wrBankM = !wrBankM; fullM++; end
         if (rAcc) begin rdBankM = !rdBankM; fullM--; end
         rdValidM = rdOk;
         if (rdOk) rdDM = rdNext;
      end
      @(posedge clk);
      #1;
      clearInputs();
      checkOutput("wr_ready", wrReady, (fullM != 2));
      checkOutput("rd_ready", rdReady, (fullM != 0));
      checkOutput("rd_valid", rdValid, rdValidM);
      checkOutput("err", err, errM);
      checkOutput("rd_d", rdD, rdDM);
   endtask

   task automatic doReset();
      clearInputs();
      rstN = 0;
      repeat (2) @(posedge clk);
      #1;
      resetModel();
      checkOutput("reset rd_d", rdD, 8'h00);
      checkOutput("reset rd_valid", rdValid, 1'b0);
      checkOutput("reset wr_ready", wrReady, 1'b1);
      checkOutput("reset rd_ready", rdReady, 1'b0);
      checkOutput("reset err", err, 1'b0);
      rstN = 1;
   endtask

   task automatic writeSample(input int ch, input int idx, input logic [7:0] d);
      wrWe = 1; wrCh = 2'(ch); wrIdx = 6'(idx); wrD = d;
      applyStimulus();
   endtask

   task automatic readSample(input int ch, input int idx);
      rdEn = 1; rdCh = 2'(ch); rdIdx = 6'(idx);
      applyStimulus();
   endtask

   initial begin
      wrCh = 0; rdCh = 0; wrIdx = 0; rdIdx = 0; wrD = 0;
      w2Ch = 0; r2Ch = 0; w2Idx = 0; r2Idx = 0; w2D = 0;
      clearInputs();
      rstN = 0;
      #1;
      doReset();
      applyStimulus();

      // Single bank write then read-back with one-cycle latency
      for (int c = 0; c < 3; c++)
         for (int i = 0; i < 64; i++)
            writeSample(c, i, 8'(c*64 + i));
      wrDone = 1; applyStimulus();
      checkOutput("t1 wr_ready", wrReady, 1'b1);
      checkOutput("t1 rd_ready", rdReady, 1'b1);
      readSample(1, 5);
      checkOutput("t1 rd_d", rdD, 8'h45);
      checkOutput("t1 rd_valid", rdValid, 1'b1);

      // Both banks full, blocked write, bank swap on rd_done
      doReset();
      for (int c = 0; c < 3; c++)
         for (int i = 0; i < 64; i++)
            writeSample(c, i, 8'(8'hA0 + i));
      wrDone = 1; applyStimulus();
      for (int c = 0; c < 3; c++)
         for (int i = 0; i < 64; i++)
            writeSample(c, i, 8'(8'hB0 + i));
      wrDone = 1; applyStimulus();
      checkOutput("t2 wr_ready", wrReady, 1'b0);
      writeSample(0, 0, 8'h55);
      checkOutput("t2 blocked err", err, 1'b1);
      readSample(0, 0);
      checkOutput("t2 bank0 idx0", rdD, 8'hA0);
      readSample(2, 10);
      checkOutput("t2 bank0 idx10", rdD, 8'hAA);
      rdDone = 1; applyStimulus();
      readSample(1, 3);
      checkOutput("t2 bank1 idx3", rdD, 8'hB3);

      // Simultaneous wr_done/rd_done while half full
      for (int i = 0; i < 8; i++)
         writeSample(0, i, 8'($urandom));
      wrDone = 1; rdDone = 1; applyStimulus();
      checkOutput("t3 wr_ready", wrReady, 1'b1);
      checkOutput("t3 rd_ready", rdReady, 1'b1);
      readSample(0, 3);
      readSample(1, 3);
      checkOutput("t3 read swapped bank", rdD, 8'hA3);

      // Illegal reads, done while empty, out-of-range channel
      flush = 1; applyStimulus();
      checkOutput("t4 err cleared", err, 1'b0);
      readSample(0, 1);
      checkOutput("t4 empty rd err", err, 1'b1);
      checkOutput("t4 empty rd_valid", rdValid, 1'b0);
      checkOutput("t4 rd_d hold", rdD, 8'hA3);
      flush = 1; applyStimulus();
      rdDone = 1; applyStimulus();
      checkOutput("t4 rd_done empty err", err, 1'b1);
      flush = 1; applyStimulus();
      writeSample(3, 0, 8'h77);
      checkOutput("t4 wr_ch oob err", err, 1'b1);

      // Flush from full with err set
      flush = 1; applyStimulus();
      wrDone = 1; applyStimulus();
      wrDone = 1; applyStimulus();
      wrDone = 1; applyStimulus();
      checkOutput("t5 full err", err, 1'b1);
      checkOutput("t5 full wr_ready", wrReady, 1'b0);
      flush = 1; applyStimulus();
      checkOutput("t5 flush wr_ready", wrReady, 1'b1);
      checkOutput("t5 flush rd_ready", rdReady, 1'b0);
      checkOutput("t5 flush err", err, 1'b0);

      // Asynchronous reset in the middle of a read burst
      wrDone = 1; applyStimulus();
      for (int i = 58; i <= 60; i++)
         readSample(2, i);
      checkOutput("t6 pre-reset rd_d", rdD, 8'hDC);
      rdEn = 1; rdCh = 2; rdIdx = 6'd57;
      #2 rstN = 0;
      #1;
      checkOutput("t6 async rd_d", rdD, 8'h00);
      checkOutput("t6 async rd_valid", rdValid, 1'b0);
      checkOutput("t6 async rd_ready", rdReady, 1'b0);
      clearInputs();
      resetModel();
      @(posedge clk);
      #3 rstN = 1;
      applyStimulus();

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         wrWe   = ($urandom_range(0, 1) == 1);
         wrCh   = 2'($urandom_range(0, 3));
         wrIdx  = 6'($urandom);
         wrD    = 8'($urandom);
         wrDone = ($urandom_range(0, 7) == 0);
         rdEn   = ($urandom_range(0, 1) == 1);
         rdCh   = 2'($urandom_range(0, 3));
         rdIdx  = 6'($urandom);
         rdDone = ($urandom_range(0, 7) == 0);
         flush  = ($urandom_range(0, 31) == 0);
         applyStimulus();
      end

      // Wider samples and four channels
      for (int c = 0; c < 4; c++)
         for (int i = 0; i < 64; i++) begin
            w2We = 1; w2Ch = 2'(c); w2Idx = 6'(i); w2D = 12'(c*64 + i);
            applyStimulus();
         end
      w2Done = 1; applyStimulus();
      checkOutput("w12 wr_ready", w2Ready, 1'b1);
      checkOutput("w12 rd_ready", r2Ready, 1'b1);
      r2En = 1; r2Ch = 2'd1; r2Idx = 6'd5; applyStimulus();
      checkOutput("w12 rd_d ch1", r2D, 12'h045);
      checkOutput("w12 rd_valid", r2Valid, 1'b1);
      r2En = 1; r2Ch = 2'd3; r2Idx = 6'd63; applyStimulus();
      checkOutput("w12 rd_d ch3", r2D, 12'h0FF);
      w2We = 1; w2Ch = 2'd3; w2Idx = 6'd7; w2D = 12'hABC; applyStimulus();
      w2Done = 1; r2Done = 1; applyStimulus();
      r2En = 1; r2Ch = 2'd3; r2Idx = 6'd7; applyStimulus();
      checkOutput("w12 rd_d wide", r2D, 12'hABC);
      checkOutput("w12 err", err2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
